// File: rtl/bin_cnt_pkg.sv
// Shared types and defaults for the binary counter and its sequencer.
package bin_cnt_pkg;

    localparam int unsigned CNT_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } cnt_seq_state_t;

endpackage

// File: rtl/bin_cnt_dist.sv
// Mod-2^N remaining distance from counter value to end value, plus end-match flag.
module bin_cnt_dist
    import bin_cnt_pkg::*;
#(
    parameter int unsigned N = CNT_W_DEFAULT
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] end_val,
    input  logic         up,
    output logic         match_c
);

    logic [N-1:0] remaining;

    // Steps still to go in the counting direction; zero means the counter sits on end_val.
    always_comb begin
        remaining = up ? N'(end_val - q) : N'(q - end_val);
        match_c   = (remaining == '0);
    end

endmodule

// File: rtl/bin_cnt_seq_ctrl.sv
// Job sequencer for universal_bin_cnt: load start value, count to end value, stop.
// Optional build macro BIN_CNT_SEQ_AUTO_RELOAD_EN adds cmd_loop for continuous reload.
module bin_cnt_seq_ctrl
    import bin_cnt_pkg::*;
#(
    parameter int unsigned N = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_start,
    input  logic [N-1:0] cmd_end,
    input  logic         cmd_up,
`ifdef BIN_CNT_SEQ_AUTO_RELOAD_EN
    input  logic         cmd_loop,
`endif
    input  logic         hold,
    input  logic         abort,
    output logic         cnt_syn_clr,
    output logic         cnt_load,
    output logic         cnt_en,
    output logic         cnt_up,
    output logic [N-1:0] cnt_d,
    input  logic [N-1:0] cnt_q,
    output logic         busy,
    output logic         done,
    output logic         aborted
);

    cnt_seq_state_t state_q, state_d;
    logic [N-1:0]   start_q, start_d;
    logic [N-1:0]   end_q, end_d;
    logic           up_q, up_d;
    logic           aborted_q, aborted_d;
`ifdef BIN_CNT_SEQ_AUTO_RELOAD_EN
    logic           loop_q, loop_d;
    logic           loop_done_q, loop_done_d;
`endif
    logic           match_c;

    bin_cnt_dist #(.N(N)) u_dist (
        .q       (cnt_q),
        .end_val (end_q),
        .up      (up_q),
        .match_c (match_c)
    );

    // State and job registers; synchronous reset returns to an empty IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            start_q     <= '0;
            end_q       <= '0;
            up_q        <= 1'b0;
            aborted_q   <= 1'b0;
`ifdef BIN_CNT_SEQ_AUTO_RELOAD_EN
            loop_q      <= 1'b0;
            loop_done_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            end_q       <= end_d;
            up_q        <= up_d;
            aborted_q   <= aborted_d;
`ifdef BIN_CNT_SEQ_AUTO_RELOAD_EN
            loop_q      <= loop_d;
            loop_done_q <= loop_done_d;
`endif
        end
    end

    // Next-state and output decode; everything is forced low while rst is high.
    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        end_d       = end_q;
        up_d        = up_q;
        aborted_d   = 1'b0;
`ifdef BIN_CNT_SEQ_AUTO_RELOAD_EN
        loop_d      = loop_q;
        loop_done_d = 1'b0;
`endif
        cmd_ready   = 1'b0;
        cnt_syn_clr = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_up      = 1'b0;
        cnt_d       = '0;
        busy        = 1'b0;
        done        = 1'b0;
        aborted     = 1'b0;

        if (!rst) begin
            busy    = (state_q != IDLE);
            aborted = aborted_q;
`ifdef BIN_CNT_SEQ_AUTO_RELOAD_EN
            done    = loop_done_q;
`endif
            unique case (state_q)
                IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        start_d = cmd_start;
                        end_d   = cmd_end;
                        up_d    = cmd_up;
`ifdef BIN_CNT_SEQ_AUTO_RELOAD_EN
                        loop_d  = cmd_loop;
`endif
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    cnt_load = 1'b1;
                    cnt_d    = start_q;
                    cnt_up   = up_q;
                    state_d  = RUN;
                end
                RUN: begin
                    cnt_up = up_q;
                    cnt_en = ~hold & ~match_c;
                    if (match_c) begin
`ifdef BIN_CNT_SEQ_AUTO_RELOAD_EN
                        if (loop_q) begin
                            state_d     = LOAD;
                            loop_done_d = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
`else
                        state_d = DONE;
`endif
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // Abort wins over hold, load and end-match; clears the counter and reports once.
            if (abort && busy) begin
                cnt_syn_clr = 1'b1;
                cnt_en      = 1'b0;
                cnt_load    = 1'b0;
                done        = 1'b0;
                state_d     = IDLE;
                aborted_d   = 1'b1;
`ifdef BIN_CNT_SEQ_AUTO_RELOAD_EN
                loop_done_d = 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bin_cnt_seq_ctrl.sv
// Directed bench for bin_cnt_seq_ctrl with a behavioural universal_bin_cnt in the loop.
module tb_bin_cnt_seq_ctrl;

    localparam int unsigned N = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [N-1:0] cmd_start = '0;
    logic [N-1:0] cmd_end = '0;
    logic         cmd_up = 1'b0;
`ifdef BIN_CNT_SEQ_AUTO_RELOAD_EN
    logic         cmd_loop = 1'b0;
`endif
    logic         hold = 1'b0;
    logic         abort = 1'b0;
    logic         cnt_syn_clr, cnt_load, cnt_en, cnt_up;
    logic [N-1:0] cnt_d;
    logic [N-1:0] cnt_q = '0;
    logic         busy, done, aborted;

    int errors = 0;
    int checks = 0;

    bin_cnt_seq_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_start   (cmd_start),
        .cmd_end     (cmd_end),
        .cmd_up      (cmd_up),
`ifdef BIN_CNT_SEQ_AUTO_RELOAD_EN
        .cmd_loop    (cmd_loop),
`endif
        .hold        (hold),
        .abort       (abort),
        .cnt_syn_clr (cnt_syn_clr),
        .cnt_load    (cnt_load),
        .cnt_en      (cnt_en),
        .cnt_up      (cnt_up),
        .cnt_d       (cnt_d),
        .cnt_q       (cnt_q),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    // Behavioural counter: syn_clr > load > en.
    always @(posedge clk) begin
        if (rst || cnt_syn_clr) cnt_q <= '0;
        else if (cnt_load)      cnt_q <= cnt_d;
        else if (cnt_en)        cnt_q <= cnt_up ? cnt_q + 5'd1 : cnt_q - 5'd1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string        name;
        logic [N-1:0] s;
        logic [N-1:0] e;
        logic         up;
        int           hold_from;
        int           hold_len;
        int           abort_at;
        int           exp_done;
        int           exp_abort;
        logic [N-1:0] exp_q;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        int done_cyc = 0, done_n = 0, ab_cyc = 0;
        bit en_at_end = 0, load_ok = 0, seq_ok = 1, syn_ok = 0, fin = 0, stop_model = 0;
        logic [N-1:0] eq;
        eq = v.s;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_start = v.s; cmd_end = v.e; cmd_up = v.up;
        #1 check({v.name, "_ready_idle"}, int'(cmd_ready), 1);
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            hold  = (v.hold_len > 0) && (k >= v.hold_from) && (k < v.hold_from + v.hold_len);
            abort = (k == v.abort_at);
            #1;
            if (k == 1) load_ok = cnt_load && (cnt_d == v.s) && !cnt_en && !cmd_ready && busy;
            if (done) begin done_n++; done_cyc = k; end
            if (aborted) ab_cyc = k;
            if (cnt_en && cnt_q == v.e) en_at_end = 1;
            if (k == v.abort_at) syn_ok = cnt_syn_clr && !cnt_en && !cnt_load;
            if (k >= 2 && busy && !done && !stop_model) begin
                if (cnt_q != eq) seq_ok = 0;
                if (!hold && eq != v.e && k != v.abort_at) eq = v.up ? eq + 5'd1 : eq - 5'd1;
            end
            if (k == v.abort_at) stop_model = 1;
            if (k >= 2 && !busy) begin fin = 1; break; end
        end
        hold = 1'b0; abort = 1'b0;
        check({v.name, "_finished"}, int'(fin), 1);
        check({v.name, "_load_cycle1"}, int'(load_ok), 1);
        check({v.name, "_done_cycle"}, done_cyc, v.exp_done);
        check({v.name, "_done_count"}, done_n, (v.exp_done != 0) ? 1 : 0);
        check({v.name, "_aborted_cycle"}, ab_cyc, v.exp_abort);
        check({v.name, "_en_at_end"}, int'(en_at_end), 0);
        check({v.name, "_q_sequence"}, int'(seq_ok), 1);
        check({v.name, "_final_q"}, int'(cnt_q), int'(v.exp_q));
        check({v.name, "_ready_after"}, int'(cmd_ready), 1);
        if (v.abort_at != 0) check({v.name, "_syn_clr"}, int'(syn_ok), 1);
    endtask

    initial begin
        int r1_load6, r1_load7, r1_ready_busy, cnt_w;
        logic [N-1:0] snap;

        vecs[0] = '{"up3_7",     5'd3,  5'd7,  1'b1, 0, 0, 0, 7, 0, 5'd7};
        vecs[1] = '{"dn2_30",    5'd2,  5'd30, 1'b0, 0, 0, 0, 7, 0, 5'd30};
        vecs[2] = '{"eq20",      5'd20, 5'd20, 1'b1, 0, 0, 0, 3, 0, 5'd20};
        vecs[3] = '{"hold0_5",   5'd0,  5'd5,  1'b1, 4, 3, 0, 11, 0, 5'd5};
        vecs[4] = '{"abort0_10", 5'd0,  5'd10, 1'b1, 0, 0, 6, 0, 7, 5'd0};
        vecs[5] = '{"upwrap",    5'd30, 5'd1,  1'b1, 0, 0, 0, 6, 0, 5'd1};
        vecs[6] = '{"eqdown",    5'd9,  5'd9,  1'b0, 0, 0, 0, 3, 0, 5'd9};

        // Reset: all outputs low while rst is high, IDLE decode right after.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("rst_outputs_low",
                 int'({cmd_ready, cnt_syn_clr, cnt_load, cnt_en, cnt_up, cnt_d, busy, done, aborted}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1 check("post_rst_ready", int'(cmd_ready), 1);
        check("post_rst_busy", int'(busy), 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Abort in IDLE is ignored.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1 check("idle_abort_no_pulse", int'(aborted), 0);
        check("idle_abort_ready", int'(cmd_ready), 1);

        // Back-to-back: command held through a job, reaccepted in the first IDLE cycle.
        r1_load6 = 0; r1_load7 = 0; r1_ready_busy = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_start = 5'd1; cmd_end = 5'd3; cmd_up = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            #1;
            if (k <= 5 && cmd_ready) r1_ready_busy++;
            if (k == 5) check("b2b_done_c5", int'(done), 1);
            if (k == 6) begin
                r1_load6 = int'(cnt_load);
                check("b2b_ready_c6", int'(cmd_ready), 1);
            end
            if (k == 7) begin
                r1_load7 = int'(cnt_load);
                cmd_valid = 1'b0;
            end
        end
        check("b2b_ready_while_busy", r1_ready_busy, 0);
        check("b2b_no_load_c6", r1_load6, 0);
        check("b2b_load_c7", r1_load7, 1);
        cnt_w = 0;
        while (busy && cnt_w < 40) begin @(negedge clk); #1; cnt_w++; end
        check("b2b_second_job_ends", int'(busy), 0);
        check("b2b_second_final_q", int'(cnt_q), 3);

        // Reset mid-RUN: straight back to IDLE, no done or aborted pulse.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_start = 5'd0; cmd_end = 5'd10; cmd_up = 1'b1;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("rst_mid_busy_before", int'(busy), 1);
        snap = cnt_q;
        check("rst_mid_q_counting", int'(snap), 2);
        rst = 1'b1;
        #1 check("rst_mid_outputs_low",
                 int'({cmd_ready, cnt_syn_clr, cnt_load, cnt_en, cnt_up, cnt_d, busy, done, aborted}), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_mid_busy_after", int'(busy), 0);
        check("rst_mid_ready_after", int'(cmd_ready), 1);
        check("rst_mid_pulses", int'({done, aborted}), 0);
        @(negedge clk);
        #1 check("rst_mid_pulses_next", int'({done, aborted, busy}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bin_cnt_seq_ctrl.md
Name: bin_cnt_seq_ctrl

Overview:
- Command-driven sequencer for the universal binary counter (universal_bin_cnt).
- Accepts a job of start value, end value and direction over a valid/ready handshake, then drives the counter's syn_clr/load/en/up/d controls to load, count and stop exactly on the end value.
- Raises a one-cycle done pulse when the job completes.
- Supports hold (pause) and abort; sits between a software-visible command register block and the counter instance.

Parameters:
- N, 5, counter width; must match the counter instance's N.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_start  in  N  value loaded into the counter.
- cmd_end  in  N  terminal value.
- cmd_up  in  1  1 = count up, 0 = count down.
- hold  in  1  pause counting while in RUN.
- abort  in  1  cancel the current job.
- cnt_syn_clr  out  1  to counter syn_clr.
- cnt_load  out  1  to counter load.
- cnt_en  out  1  to counter en.
- cnt_up  out  1  to counter up.
- cnt_d  out  N  to counter d.
- cnt_q  in  N  counter q, fed back.
- busy  out  1  job in progress (state != IDLE).
- done  out  1  one-cycle completion pulse.
- aborted  out  1  one-cycle abort acknowledge pulse.

Behaviour:
- Single clock domain (clk); rst is synchronous and active-high.
- On rst:
  - State goes to IDLE; start_r, end_r and up_r clear to 0.
  - While rst is high, every output is 0, cmd_ready included.
  - Outputs decode from the registered state in the cycle after rst deasserts, so cmd_ready=1 from that cycle.
- FSM states: IDLE, LOAD, RUN, DONE. Outputs decode combinationally from state, captured registers and cnt_q.
- IDLE:
  - cmd_ready=1; all cnt_* outputs are 0.
  - On cmd_valid&cmd_ready, capture cmd_start/cmd_end/cmd_up into start_r/end_r/up_r and go to LOAD.
- LOAD (exactly 1 cycle):
  - cnt_load=1, cnt_d=start_r, cnt_up=up_r, cnt_en=0, cmd_ready=0.
  - Next state RUN.
- RUN:
  - cnt_up=up_r.
  - cnt_en = ~hold & (cnt_q != end_r).
  - When cnt_q==end_r, go to DONE; cnt_en stays 0 that cycle, so the counter stops on end_r.
  - hold=1 freezes the counter; state stays RUN.
- DONE (exactly 1 cycle):
  - done=1, cnt_* outputs 0, counter keeps end_r.
  - Next state IDLE.
- Distance: D = (end_r - start_r) mod 2^N if up_r, otherwise (start_r - end_r) mod 2^N.
  - Wrap-around through 2^N-1 -> 0 (or the reverse when counting down) is legal.
- Latency with hold=0, measured from the accept edge:
  - LOAD occupies cycle 1; RUN occupies cycles 2 .. 2+D.
  - done is high in cycle 3+D.
  - start==end gives D=0, so exactly 1 RUN cycle and done in cycle 3.
- abort while busy:
  - In that same cycle: cnt_syn_clr=1, cnt_en=0, cnt_load=0.
  - Next state IDLE; aborted=1 for 1 cycle in that IDLE cycle; no done.
  - abort outranks hold, load and end-match in the same cycle.
  - abort in IDLE is ignored.
- cmd_valid while busy: not accepted (cmd_ready=0); the command must be held until IDLE.
- rst mid-job: immediate return to IDLE on the next edge; no done, no aborted.

Optional Feature:
- Macro: BIN_CNT_SEQ_AUTO_RELOAD_EN.
- Defined:
  - Adds input cmd_loop (1 bit), captured at accept into loop_r.
  - With loop_r=1, reaching end_r in RUN moves to LOAD instead of DONE, and done pulses in that LOAD cycle.
  - Period is D+2 cycles; only abort or rst ends the job.
  - With loop_r=0, behaviour is unchanged.
- Undefined: the port and loop_r are absent; every job ends via DONE.

Decomposition:
- Package bin_cnt_pkg:
  - typedef enum logic [1:0] cnt_seq_state_t {IDLE, LOAD, RUN, DONE}.
  - localparam CNT_W_DEFAULT = 5.
  - Shared with the universal_bin_cnt bench.
- One natural sub-module: bin_cnt_dist, a combinational mod-2^N distance/end-match helper. Optional; the compare can also stay inline.
- The counter itself stays outside this block; a wrapper instantiates both.

Test Plan:
- Up count: reset, then cmd start=3 end=7 up=1 -> cnt_load in cycle 1; q sequence 3,4,5,6,7; done in cycle 7; final q=7; cnt_en never asserted while q=7.
- Down count with wrap: start=2 end=30 up=0 -> q sequence 2,1,0,31,30; D=4; done in cycle 7.
- start==end=20 -> 1 RUN cycle, done in cycle 3, cnt_en never 1.
- hold high for 3 cycles mid-RUN (start=0 end=5 up=1) -> q frozen for 3 cycles, done delayed by exactly 3 cycles to cycle 11.
- abort while q=4 in RUN (start=0 end=10) -> cnt_syn_clr=1 that cycle, q=0 next cycle, aborted pulse, no done, cmd_ready=1.
- Back-to-back: cmd_valid held through a job -> second command accepted only in the first IDLE cycle after DONE. Separately, rst pulsed mid-RUN -> IDLE, busy=0, no pulses.
